l2_mem_arbiter: RTL and testbench

- Sits between the L2 miss path and main memory. Schedules L2 line refills (reads) and dirty-line evictions (writebacks) onto a single memory request port.
- Evictions are absorbed into a small write-back buffer (WB) and drained in the background. Reads win by default.
- WB-full forces a drain, and a read-streak limit prevents writeback starvation.
- Reads that hit a buffered line are forwarded from the WB without a memory access.

---
 rtl/l2_mem_arbiter_pkg.sv | 39 +++
 rtl/l2_mem_arbiter_wb_buffer.sv | 98 +++++++++
 rtl/l2_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_l2_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_arbiter_pkg.sv
// Shared types for the L2 miss path / main memory arbiter.
package cache_def;

  // Request toward main memory (rw: 1 = write, 0 = read).
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  // Line-sized data with a one-cycle completion pulse.
  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  // Dirty line leaving the L2.
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         valid;
  } evict_data_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } l2_arb_state_type;

  localparam int LINE_OFFSET_BITS = 4;

  // Lines are 16 bytes; the byte offset never reaches memory or the WB compare.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_mem_arbiter_wb_buffer.sv
// Write-back buffer: FIFO of dirty lines with an associative address compare.
// Evicts to a line already buffered merge into that entry, except into a head
// that is locked because its write is (or is about to be) in flight.
module wb_buffer
  import cache_def::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic [31:0]    push_addr_i,
  input  logic [127:0]   push_data_i,
  output logic           push_ready_o,
  input  logic           head_locked_i,
  input  logic           pop_i,
  output logic [31:0]    head_addr_o,
  output logic [127:0]   head_data_o,
  input  logic [31:0]    lookup_addr_i,
  output logic           hit_o,
  output logic [127:0]   hit_data_o,
  output logic [CW-1:0]  count_o,
  output logic           full_o,
  output logic           empty_o
);

  logic [31:0]   addr_q [DEPTH];
  logic [127:0]  data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic [PW-1:0] idx;
  logic [PW-1:0] merge_idx;
  logic [PW-1:0] wr_idx;
  logic          merge_hit;
  logic          do_push;
  logic          push_new;
  logic          do_pop;

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = ~full_o;
  assign count_o      = count_q;
  assign head_addr_o  = addr_q[head_q];
  assign head_data_o  = data_q[head_q];

  assign do_push  = push_i & ~full_o;
  assign push_new = do_push & ~merge_hit;
  assign do_pop   = pop_i & ~empty_o;
  assign wr_idx   = merge_hit ? merge_idx : tail_q;

  // Walk entries oldest to youngest so the youngest match wins both compares.
  always_comb begin
    idx        = '0;
    hit_o      = 1'b0;
    hit_data_o = '0;
    merge_hit  = 1'b0;
    merge_idx  = tail_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (addr_q[idx] == lookup_addr_i) begin
          hit_o      = 1'b1;
          hit_data_o = data_q[idx];
        end
        if ((addr_q[idx] == push_addr_i) && ((k != 0) || !head_locked_i)) begin
          merge_hit = 1'b1;
          merge_idx = idx;
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything buffered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_new) tail_q <= tail_q + PW'(1);
      if (do_pop)   head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push_new) - CW'(do_pop);
    end
  end

  // Line storage: a new entry at the tail or a merge into an existing one.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_q[wr_idx] <= push_addr_i;
      data_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Schedules L2 refills and dirty-line writebacks onto one memory port.
// Reads win by default; a full WB or a long read streak forces a drain, and
// reads that hit a buffered line are served from the WB.
// Handshakes: a request (rd_req_i / mem_req_o) is held stable while valid until
// the matching one-cycle ready pulse; an evict transfers on valid & ready.
module l2_mem_arbiter
  import cache_def::*;
#(
  parameter int WB_DEPTH        = 4,
  parameter int MAX_READ_STREAK = 8,
  localparam int CW = $clog2(WB_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  mem_req_type      rd_req_i,
  output mem_data_type     rd_data_o,
  input  evict_data_type   evict_i,
  output logic             evict_ready_o,
  output mem_req_type      mem_req_o,
  input  mem_data_type     mem_resp_i,
  output logic [CW-1:0]    wb_count_o,
  output logic             wb_empty_o,
  output l2_arb_state_type state_o
);

  localparam int SW = $clog2(MAX_READ_STREAK + 1);

  l2_arb_state_type state_q;
  l2_arb_state_type idle_next;
  logic [SW-1:0]    streak_q;
  mem_req_type      mem_req_q;
  mem_data_type     rd_data_q;

  logic [31:0]  rd_line;
  logic         wb_full;
  logic         wb_empty;
  logic         wb_hit;
  logic [127:0] wb_hit_data;
  logic [31:0]  wb_head_addr;
  logic [127:0] wb_head_data;
  logic         wb_push_ready;
  logic         head_locked;
  logic         wb_pop;
  logic         unused_ok;

  assign rd_line   = line_align(rd_req_i.addr);
  assign unused_ok = ^{rd_req_i.data, rd_req_i.rw, rd_req_i.addr[3:0], evict_i.addr[3:0]};

  // Head is frozen from the cycle WRITE is chosen so the latched request
  // always matches the entry that gets popped.
  assign head_locked = (state_q == WRITE) || ((state_q == IDLE) && (idle_next == WRITE));
  assign wb_pop      = (state_q == WRITE) && mem_resp_i.ready;

  wb_buffer #(.DEPTH(WB_DEPTH)) u_wb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (evict_i.valid),
    .push_addr_i   (line_align(evict_i.addr)),
    .push_data_i   (evict_i.data),
    .push_ready_o  (wb_push_ready),
    .head_locked_i (head_locked),
    .pop_i         (wb_pop),
    .head_addr_o   (wb_head_addr),
    .head_data_o   (wb_head_data),
    .lookup_addr_i (rd_line),
    .hit_o         (wb_hit),
    .hit_data_o    (wb_hit_data),
    .count_o       (wb_count_o),
    .full_o        (wb_full),
    .empty_o       (wb_empty)
  );

  assign evict_ready_o = wb_push_ready;
  assign wb_empty_o    = wb_empty;
  assign mem_req_o     = mem_req_q;
  assign rd_data_o     = rd_data_q;
  assign state_o       = state_q;

  // IDLE scheduling decision in priority order.
  always_comb begin
    idle_next = IDLE;
    if (wb_full)
      idle_next = WRITE;
    else if (rd_req_i.valid && wb_hit)
      idle_next = RESP;
    else if (rd_req_i.valid && (streak_q == SW'(MAX_READ_STREAK)) && !wb_empty)
      idle_next = WRITE;
    else if (rd_req_i.valid)
      idle_next = READ;
    else if (!wb_empty)
      idle_next = WRITE;
  end

  // Main FSM with registered memory request and refill outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      mem_req_q <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= idle_next;
          case (idle_next)
            READ:    mem_req_q <= '{addr: rd_line, data: '0, rw: 1'b0, valid: 1'b1};
            WRITE:   mem_req_q <= '{addr: wb_head_addr, data: wb_head_data, rw: 1'b1, valid: 1'b1};
            RESP:    rd_data_q <= '{data: wb_hit_data, ready: 1'b1};
            default: ;
          endcase
        end
        READ: begin
          if (mem_resp_i.ready) begin
            mem_req_q <= '0;
            rd_data_q <= '{data: mem_resp_i.data, ready: 1'b1};
            state_q   <= RESP;
            if (wb_empty)
              streak_q <= '0;
            else if (streak_q != SW'(MAX_READ_STREAK))
              streak_q <= streak_q + SW'(1);
          end
        end
        WRITE: begin
          if (mem_resp_i.ready) begin
            mem_req_q <= '0;
            streak_q  <= '0;
            state_q   <= IDLE;
          end
        end
        default: begin
          rd_data_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: directed scenarios plus a randomized phase,
// scored against a line-level model of what each read must return.
module tb_l2_mem_arbiter;
  import cache_def::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  mem_req_type      rd_req;
  mem_data_type     rd_data_w;
  evict_data_type   evict;
  logic             evict_ready_w;
  mem_req_type      mem_req_w;
  mem_data_type     mem_resp;
  logic [2:0]       wb_count_w;
  logic             wb_empty_w;
  l2_arb_state_type state_w;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mem_model [logic [31:0]];
  logic [127:0] shadow [logic [31:0]];
  logic [31:0]  wr_log[$];
  logic         op_log[$];
  int           mem_reads = 0;
  logic [31:0]  last_rd_addr = '0;
  int           fixed_lat = -1;

  l2_mem_arbiter #(.WB_DEPTH(4), .MAX_READ_STREAK(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rd_req_i      (rd_req),
    .rd_data_o     (rd_data_w),
    .evict_i       (evict),
    .evict_ready_o (evict_ready_w),
    .mem_req_o     (mem_req_w),
    .mem_resp_i    (mem_resp),
    .wb_count_o    (wb_count_w),
    .wb_empty_o    (wb_empty_w),
    .state_o       (state_w)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  // Power-on content of a memory line.
  function automatic logic [127:0] init_data(input logic [31:0] line);
    return {line ^ 32'hA5A5_0000, ~line, line + 32'h1111, 32'hC0DE_0000 ^ line};
  endfunction

  function automatic logic [127:0] mem_value(input logic [31:0] line);
    if (mem_model.exists(line)) return mem_model[line];
    return init_data(line);
  endfunction

  // A read must return the most recently evicted data for its line.
  function automatic logic [127:0] exp_read(input logic [31:0] a);
    logic [31:0] line;
    line = align(a);
    if (shadow.exists(line)) return shadow[line];
    return init_data(line);
  endfunction

  function automatic logic [127:0] rand_line_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_read(input logic [31:0] a, input logic rw_noise, input logic drop);
    logic got;
    got = 1'b0;
    rd_req = '{addr: a, data: '0, rw: rw_noise, valid: 1'b1};
    exp_q.push_back(exp_read(a));
    for (int t = 0; t < 400; t++) begin
      @(negedge clk_i);
      if (rd_data_w.ready) begin
        got = 1'b1;
        break;
      end
    end
    check("rd_complete", 256'(got), 256'(1));
    if (drop) rd_req.valid = 1'b0;
  endtask

  task automatic do_evict(input logic [31:0] a, input logic [127:0] d);
    logic got;
    got = 1'b0;
    evict = '{addr: a, data: d, valid: 1'b1};
    for (int t = 0; t < 400; t++) begin
      if (evict_ready_w) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    if (got) shadow[align(a)] = d;
    @(negedge clk_i);
    evict.valid = 1'b0;
    check("evict_accept", 256'(got), 256'(1));
  endtask

  task automatic wait_idle_empty(input string name);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (wb_empty_w && (state_w == IDLE) && !mem_req_w.valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check(name, 256'(ok), 256'(1));
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int          lat;
    logic        busy;
    mem_req_type seen;
    mem_resp = '0;
    busy = 1'b0;
    lat  = 0;
    seen = '0;
    forever begin
      @(negedge clk_i);
      mem_resp = '0;
      if (!rst_ni) begin
        busy = 1'b0;
      end else if (mem_req_w.valid) begin
        if (!busy) begin
          busy = 1'b1;
          seen = mem_req_w;
          lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (lat == 0) begin
          check("mem_req_stable", 256'(mem_req_w), 256'(seen));
          check("mem_req_aligned", 256'(mem_req_w.addr[3:0]), 256'(0));
          op_log.push_back(mem_req_w.rw);
          if (mem_req_w.rw) begin
            mem_model[mem_req_w.addr] = mem_req_w.data;
            wr_log.push_back(mem_req_w.addr);
          end else begin
            mem_reads++;
            last_rd_addr  = mem_req_w.addr;
            mem_resp.data = mem_value(mem_req_w.addr);
          end
          mem_resp.ready = 1'b1;
          busy = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    logic [127:0] e;
    if (rst_ni && rd_data_w.ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got ready with data %h, required no response", rd_data_w.data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", 256'(rd_data_w.data), 256'(e));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          rd_before;
    int          wr_before;
    logic        seen;
    logic [31:0] line;

    rst_ni = 1'b0;
    rd_req = '0;
    evict  = '0;
    repeat (3) @(negedge clk_i);
    check("rst_mem_req", 256'(mem_req_w), 256'(0));
    check("rst_rd_data", 256'(rd_data_w), 256'(0));
    check("rst_evict_ready", 256'(evict_ready_w), 256'(1));
    check("rst_wb_count", 256'(wb_count_w), 256'(0));
    check("rst_wb_empty", 256'(wb_empty_w), 256'(1));
    check("rst_state", 256'(state_w), 256'(IDLE));
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 1: plain refill from memory with an unaligned address.
    fixed_lat = 3;
    rd_before = mem_reads;
    wr_before = wr_log.size();
    do_read(32'h0000_1234, 1'b0, 1'b1);
    @(negedge clk_i);
    check("t1_rd_data_one_cycle", 256'(rd_data_w), 256'(0));
    check("t1_mem_reads", 256'(mem_reads - rd_before), 256'(1));
    check("t1_mem_addr", 256'(last_rd_addr), 256'(32'h0000_1230));
    check("t1_no_write", 256'(wr_log.size() - wr_before), 256'(0));
    wait_idle_empty("t1_idle");

    // 2: two evicts drain in FIFO order.
    fixed_lat = 4;
    wr_log.delete();
    do_evict(32'h0000_0100, rand_line_data());
    do_evict(32'h0000_0200, rand_line_data());
    check("t2_count_two", 256'(wb_count_w), 256'(2));
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (wb_count_w == 3'd1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("t2_count_one", 256'(seen), 256'(1));
    wait_idle_empty("t2_drained");
    check("t2_wb_empty", 256'(wb_empty_w), 256'(1));
    check("t2_write_count", 256'(wr_log.size()), 256'(2));
    if (wr_log.size() == 2) begin
      check("t2_write0", 256'(wr_log[0]), 256'(32'h0000_0100));
      check("t2_write1", 256'(wr_log[1]), 256'(32'h0000_0200));
    end

    // 3: read hits a buffered line and is forwarded without a memory read.
    fixed_lat = 6;
    wr_log.delete();
    rd_before = mem_reads;
    do_evict(32'h0000_0300, rand_line_data());
    do_read(32'h0000_0308, 1'b0, 1'b1);
    check("t3_no_mem_read", 256'(mem_reads - rd_before), 256'(0));
    wait_idle_empty("t3_drained");
    check("t3_write_count", 256'(wr_log.size()), 256'(1));
    if (wr_log.size() == 1) check("t3_write_addr", 256'(wr_log[0]), 256'(32'h0000_0300));

    // 4: WB fills behind a slow read; a full WB is drained before the next read.
    fixed_lat = 8;
    fork
      begin
        for (int i = 0; i < 3; i++) do_read(32'h0000_8000 + 32'(i * 16), 1'b0, i == 2);
      end
      begin
        @(negedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) do_evict(32'h0000_4000 + 32'(i * 16), rand_line_data());
      end
      begin
        logic full_seen;
        full_seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
          @(negedge clk_i);
          if (wb_count_w == 3'd4) begin
            full_seen = 1'b1;
            break;
          end
        end
        check("t4_full_seen", 256'(full_seen), 256'(1));
        check("t4_evict_ready_full", 256'(evict_ready_w), 256'(0));
        for (int t = 0; t < 200; t++) begin
          if (state_w == IDLE) break;
          @(negedge clk_i);
        end
        @(negedge clk_i);
        check("t4_write_first", 256'(state_w), 256'(WRITE));
        check("t4_write_rw", 256'(mem_req_w.rw), 256'(1));
        for (int t = 0; t < 200; t++) begin
          @(posedge clk_i);
          if (mem_resp.ready) break;
        end
        @(negedge clk_i);
        check("t4_evict_ready_after_pop", 256'(evict_ready_w), 256'(1));
        check("t4_count_after_pop", 256'(wb_count_w), 256'(3));
      end
    join
    wait_idle_empty("t4_drained");

    // 5: a long read streak with one buffered line forces a write after 8 reads.
    fixed_lat = 2;
    op_log.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) do_read(32'h0000_9000 + 32'(i * 16), 1'b0, i == 9);
      end
      begin
        @(negedge clk_i);
        do_evict(32'h0000_5000, rand_line_data());
      end
    join
    wait_idle_empty("t5_drained");
    check("t5_op_count", 256'(op_log.size()), 256'(11));
    for (int i = 0; i < op_log.size(); i++)
      check($sformatf("t5_op%0d_rw", i), 256'(op_log[i]), 256'(i == 8));

    // Randomized mix of evicts and reads over a small line pool.
    fixed_lat = -1;
    for (int n = 0; n < 80; n++) begin
      line = 32'h0000_2000 + 32'($urandom_range(0, 7) * 16);
      if ($urandom_range(0, 1) == 0)
        do_evict(line + 32'($urandom_range(0, 15)), rand_line_data());
      else
        do_read(line + 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_idle_empty("rand_drained");
    check("rand_exp_q_empty", 256'(exp_q.size()), 256'(0));
    foreach (shadow[k]) begin
      check($sformatf("mem_line_%h", k), 256'(mem_value(k)), 256'(shadow[k]));
    end

    // 6: reset in the middle of a write with three lines buffered.
    fixed_lat = 30;
    do_evict(32'h0000_6000, rand_line_data());
    do_evict(32'h0000_6010, rand_line_data());
    do_evict(32'h0000_6020, rand_line_data());
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if ((state_w == WRITE) && (wb_count_w == 3'd3)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("t6_write_with_three", 256'(seen), 256'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_mem_valid", 256'(mem_req_w.valid), 256'(0));
    check("t6_rst_wb_count", 256'(wb_count_w), 256'(0));
    check("t6_rst_evict_ready", 256'(evict_ready_w), 256'(1));
    check("t6_rst_wb_empty", 256'(wb_empty_w), 256'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("t6_post_state", 256'(state_w), 256'(IDLE));
    check("t6_post_mem_valid", 256'(mem_req_w.valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
